// File: rtl/usb_bus_arb_pkg.sv
// Shared definitions for the USB register/EP-status bus arbiter:
// bus widths, FSM state encoding and an index-width helper.
package usb_bus_arb_pkg;

  localparam int USB_BUS_AW = 12;
  localparam int USB_BUS_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  // Width of a requester index; never below one bit.
  function automatic int arb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/usb_arb_rr.sv
// Combinational rotating-priority picker. Scans last+1, last+2, ... (mod N_REQ)
// and returns the first requesting position as one-hot plus index.
module usb_arb_rr
  import usb_bus_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IW    = arb_idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             valid_o
);

  // Walk offsets in rotation order; the first requesting position wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      for (int p = 0; p < N_REQ; p++) begin
        if (!valid_o && req_i[p] && (p == ((int'(last_i) + off) % N_REQ))) begin
          valid_o  = 1'b1;
          gnt_o[p] = 1'b1;
          idx_o    = IW'(p);
        end
      end
    end
  end

endmodule

// File: rtl/usb_bus_arb.sv
// Round-robin arbiter for the USB core register/EP-status bus.
// FSM IDLE -> BUSY -> GAP -> IDLE; the GAP cycle forces wb_cyc low between owners.
// Optional BUSY watchdog enabled by defining USB_ARB_TIMEOUT_EN.
module usb_bus_arb
  import usb_bus_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [USB_BUS_AW*N_REQ-1:0]   req_addr,
  input  logic [USB_BUS_DW*N_REQ-1:0]   req_wdata,
  input  logic [N_REQ-1:0]              req_we,
  input  logic [N_REQ-1:0]              req_cyc,
  output logic [N_REQ-1:0]              req_ack,
  output logic [N_REQ-1:0]              req_err,
  output logic [USB_BUS_DW-1:0]         req_rdata,
  output logic [N_REQ-1:0]              grant,
  output logic [USB_BUS_AW-1:0]         wb_addr,
  output logic [USB_BUS_DW-1:0]         wb_wdata,
  output logic                          wb_we,
  output logic                          wb_cyc,
  input  logic [USB_BUS_DW-1:0]         wb_rdata,
  input  logic                          wb_ack,
  output logic                          timeout
);

  localparam int IW = arb_idx_w(N_REQ);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    last_q, last_d;

  logic [N_REQ-1:0] pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;
  logic             own_cyc;
  logic             expire;

  usb_arb_rr #(.N_REQ(N_REQ), .IW(IW)) u_rr (
    .req_i   (req_cyc),
    .last_i  (last_q),
    .gnt_o   (pick_onehot),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // grant_q is non-zero only in BUSY, so this is the owner's live cyc.
  assign own_cyc = |(req_cyc & grant_q);

`ifdef USB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter runs only in BUSY and sits at zero otherwise, so it is clear on BUSY entry.
  always_comb begin
    cnt_d = (state_q == ST_BUSY) ? cnt_q + CW'(1) : '0;
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // An ack in the final cycle takes precedence over the abort.
  assign expire = (state_q == ST_BUSY) && own_cyc && !wb_ack &&
                  (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign expire = 1'b0;
`endif

  // State, owner and rotation pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IW'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, release on ack/drop/abort, one GAP cycle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_onehot;
          last_d  = pick_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!own_cyc || wb_ack || expire) begin
          grant_d = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs: ack/err steered to the owner, cyc follows the owner.
  always_comb begin
    req_ack = '0;
    req_err = '0;
    timeout = 1'b0;
    wb_cyc  = 1'b0;
    if (state_q == ST_BUSY) begin
      wb_cyc  = own_cyc;
      req_ack = (own_cyc && wb_ack) ? grant_q : '0;
      req_err = expire ? grant_q : '0;
      timeout = expire;
    end
  end

  assign grant     = grant_q;
  assign req_rdata = wb_rdata;

  // Per-requester masked terms for the AND-OR bus mux.
  logic [USB_BUS_AW-1:0] addr_term  [N_REQ];
  logic [USB_BUS_DW-1:0] wdata_term [N_REQ];
  logic [N_REQ-1:0]      we_term;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_mux
      assign addr_term[gi]  = req_addr[USB_BUS_AW*gi +: USB_BUS_AW] & {USB_BUS_AW{grant_q[gi]}};
      assign wdata_term[gi] = req_wdata[USB_BUS_DW*gi +: USB_BUS_DW] & {USB_BUS_DW{grant_q[gi]}};
      assign we_term[gi]    = req_we[gi] & grant_q[gi];
    end
  endgenerate

  // OR the masked terms; all-zero grant yields an all-zero bus.
  always_comb begin
    wb_addr  = '0;
    wb_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      wb_addr  = wb_addr | addr_term[i];
      wb_wdata = wb_wdata | wdata_term[i];
    end
    wb_we = |we_term;
  end

endmodule
